// File: rtl/water_tank_model_pkg.sv
// -----------------------------------------------------------------------------
// water_tank_model_pkg
// Shared water-supply definitions for the tank model and its helpers:
//   - default full-tank level and sensor thresholds
//   - fault_sel encodings used when WATER_FAULT_INJECT_EN is defined
//   - helper that clamps a signed intermediate level into 0..max
// Ports: none (package only).
// -----------------------------------------------------------------------------
package water_tank_model_pkg;

  // Default full-tank level (8-bit level range)
  localparam int DEFAULT_LEVEL_MAX  = 200;

  // Default level-sensor thresholds (LOW < MID < HIGH <= LEVEL_MAX)
  localparam int DEFAULT_LOW_TH     = 50;
  localparam int DEFAULT_MID_TH     = 100;
  localparam int DEFAULT_HIGH_TH    = 150;

  // Default update timing and step sizes
  localparam int DEFAULT_PRESCALE   = 4;
  localparam int DEFAULT_FILL_STEP  = 5;
  localparam int DEFAULT_DRAIN_STEP = 3;

  // fault_sel encodings for the optional sensor fault injection
  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_LOW_STUCK = 2'b01;  // low_level forced 0
  localparam logic [1:0] FAULT_MID_STUCK = 2'b10;  // mid_level forced 0
  localparam logic [1:0] FAULT_HIGH_SET  = 2'b11;  // high_level forced 1

  // Sensor bundle, packed high..low so it reads like a thermometer code
  typedef struct packed {
    logic high;
    logic mid;
    logic low;
  } sensor_t;

  // Clamp a signed 10-bit candidate level into 0..max_level.
  function automatic logic [7:0] sat_level(input logic signed [9:0] cand,
                                           input logic [7:0]        max_level);
    logic signed [9:0] max_s;
    max_s = $signed({2'b00, max_level});
    if (cand > max_s)
      sat_level = max_level;
    else if (cand < 10'sd0)
      sat_level = 8'd0;
    else
      sat_level = cand[7:0];
  endfunction

endpackage

// File: rtl/water_tick_gen.sv
// -----------------------------------------------------------------------------
// water_tick_gen
// Level-update prescaler. Counts 0..PRESCALE-1 and wraps; strobe is high for
// the whole cycle in which the count sits at PRESCALE-1, so the consumer acts
// on the following rising edge.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (count returns to 0)
//   restart  in   synchronous restart, count forced to 0 on this edge
//   strobe   out  update strobe (combinational from the count)
// -----------------------------------------------------------------------------
module water_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic strobe
);

  // Counter must be at least one bit wide even when PRESCALE == 1
  localparam int              CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // Free-running modulo-PRESCALE counter; a restart (tank preset) realigns
  // the phase so the next update lands a full PRESCALE cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (restart)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + CW'(1);
  end

  // With PRESCALE == 1 the count is always 0 == LAST, so every cycle strobes
  assign strobe = (count == LAST);

endmodule

// File: rtl/water_tank_model.sv
// -----------------------------------------------------------------------------
// water_tank_model
// Behavioural water-tank emulator. Every prescaler strobe the level moves by
// the inflow step (fill_valve) minus the outflow step (drain), saturating to
// 0..LEVEL_MAX with sticky overflow/underflow flags. Three thermometer-coded
// level sensors are decoded combinationally from the level register.
//
// Optional feature: define WATER_FAULT_INJECT_EN to add the fault_sel input,
// which forces individual sensor outputs to emulate sensor faults.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   fill_valve   in   inflow valve open
//   drain        in   outflow active
//   load         in   one-cycle level preset request
//   load_value   in   [7:0] preset level (clamped to LEVEL_MAX)
//   clear_flags  in   clear sticky overflow/underflow
//   fault_sel    in   [1:0] sensor fault select (WATER_FAULT_INJECT_EN only)
//   level        out  [7:0] current level
//   low_level    out  level >= LOW_TH
//   mid_level    out  level >= MID_TH
//   high_level   out  level >= HIGH_TH
//   overflow     out  sticky: an update tried to exceed LEVEL_MAX
//   underflow    out  sticky: an update tried to go below 0
// -----------------------------------------------------------------------------
module water_tank_model
  import water_tank_model_pkg::*;
#(
  parameter int LEVEL_MAX  = DEFAULT_LEVEL_MAX,
  parameter int PRESCALE   = DEFAULT_PRESCALE,
  parameter int FILL_STEP  = DEFAULT_FILL_STEP,
  parameter int DRAIN_STEP = DEFAULT_DRAIN_STEP,
  parameter int LOW_TH     = DEFAULT_LOW_TH,
  parameter int MID_TH     = DEFAULT_MID_TH,
  parameter int HIGH_TH    = DEFAULT_HIGH_TH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fill_valve,
  input  logic       drain,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       clear_flags,
`ifdef WATER_FAULT_INJECT_EN
  input  logic [1:0] fault_sel,
`endif
  output logic [7:0] level,
  output logic       low_level,
  output logic       mid_level,
  output logic       high_level,
  output logic       overflow,
  output logic       underflow
);

  localparam logic [7:0]        LMAX8   = 8'(LEVEL_MAX);
  localparam logic signed [9:0] LMAX10  = 10'(LEVEL_MAX);
  localparam logic signed [9:0] FILL10  = 10'(FILL_STEP);
  localparam logic signed [9:0] DRAIN10 = 10'(DRAIN_STEP);
  localparam logic [7:0]        LOW8    = 8'(LOW_TH);
  localparam logic [7:0]        MID8    = 8'(MID_TH);
  localparam logic [7:0]        HIGH8   = 8'(HIGH_TH);

  logic              tick;
  logic signed [9:0] net;
  logic signed [9:0] cand;
  logic [7:0]        load_clamped;
  logic              update;
  logic              ovf_hit;
  logic              unf_hit;
  sensor_t           sens_raw;
  sensor_t           sens_out;

  // A load realigns the prescaler so the first update after a preset is a
  // full period away.
  water_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (load),
    .strobe  (tick)
  );

  // Net change and candidate level, kept at 10-bit signed width so both the
  // overshoot above LEVEL_MAX and the dip below zero stay representable.
  // A load on the same edge wins, so the strobe's update is suppressed.
  always_comb begin
    net = 10'sd0;
    if (fill_valve)
      net = net + FILL10;
    if (drain)
      net = net - DRAIN10;
    cand         = $signed({2'b00, level}) + net;
    load_clamped = (load_value > LMAX8) ? LMAX8 : load_value;
    update       = tick && !load;
    ovf_hit      = update && (cand > LMAX10);
    unf_hit      = update && (cand < 10'sd0);
  end

  // Level register: preset has priority, otherwise saturating update on strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      level <= 8'd0;
    else if (load)
      level <= load_clamped;
    else if (update)
      level <= sat_level(cand, LMAX8);
  end

  // Sticky saturation flags; a new saturation event beats a coincident clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_hit)
        overflow <= 1'b1;
      else if (clear_flags)
        overflow <= 1'b0;

      if (unf_hit)
        underflow <= 1'b1;
      else if (clear_flags)
        underflow <= 1'b0;
    end
  end

  // Thermometer-coded sensors straight off the level register
  always_comb begin
    sens_raw.low  = (level >= LOW8);
    sens_raw.mid  = (level >= MID8);
    sens_raw.high = (level >= HIGH8);
  end

`ifdef WATER_FAULT_INJECT_EN
  // Fault emulation only touches the sensor view, never level or flags
  always_comb begin
    sens_out = sens_raw;
    case (fault_sel)
      FAULT_LOW_STUCK: sens_out.low  = 1'b0;
      FAULT_MID_STUCK: sens_out.mid  = 1'b0;
      FAULT_HIGH_SET:  sens_out.high = 1'b1;
      default:         sens_out = sens_raw;
    endcase
  end
`else
  // No fault injection: sensors are always thermometer-consistent
  always_comb begin
    sens_out = sens_raw;
  end
`endif

  assign low_level  = sens_out.low;
  assign mid_level  = sens_out.mid;
  assign high_level = sens_out.high;

endmodule
